// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types for the data-memory arbiter.
//   owner_e   - which requester performed the last transfer
//   state_e   - arbiter FSM state (owner of the last transfer, or idle)
//   mem_req_t - one memory request (write enable, address, write data)
package dmem_arb_pkg;

  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 8;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CPU   = 2'd1,
    S_HOST  = 2'd2,
    S_HLOCK = 2'd3
  } state_e;

  typedef struct packed {
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdat;
  } mem_req_t;

endpackage

// File: rtl/sat_ctr.sv
// sat_ctr: saturating up-counter with synchronous clear.
//   clk    - clock
//   rst_n  - async active-low reset, counter -> 0
//   i_inc  - count up by one (holds at MAX)
//   i_clr  - clear to 0, wins over i_inc
//   o_cnt  - current count
module sat_ctr #(
  parameter int W   = 3,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_cnt <= '0;
    else if (i_clr)                        r_cnt <= '0;
    else if (i_inc && (r_cnt != W'(MAX)))  r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU load/store
// path and the host loader/debug port. At most one grant per cycle, granted
// combinationally; read data is registered and returned one cycle later.
//   clk, reset                          - clock, async active-low reset
//   cpu_req/we/addr/wdat                - CPU request (held until granted)
//   cpu_gnt, cpu_stall                  - transfer this cycle / core must wait
//   cpu_rvalid, cpu_rdat                - one-cycle read-data-valid pulse, data
//   host_req/we/addr/wdat, host_lock    - host request, burst lock
//   host_gnt, host_rvalid, host_rdat    - as for the CPU
//   mem_wr_en, mem_addr, mem_wdat       - dat_mem write/address/data
//   mem_rdat                            - dat_mem combinational read data
// AW/DW must match the widths of mem_req_t in dmem_arb_pkg.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW      = DMEM_AW,
  parameter int DW      = DMEM_DW,
  parameter int MAXWAIT = 4,
  parameter int MAXLOCK = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdat,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdat,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdat,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdat,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdat,
  input  logic [DW-1:0] mem_rdat
);

  localparam int WW = $clog2(MAXWAIT + 1);
  localparam int LW = $clog2(MAXLOCK + 1);

  state_e        r_state, w_state_nxt;
  owner_e        r_last,  w_last_nxt;
  logic          w_cpu_gnt, w_host_gnt;
  logic [WW-1:0] w_cpu_wait, w_host_wait;
  logic [LW-1:0] w_lock_cnt;
  logic          w_cpu_starved, w_host_starved;
  logic          r_cpu_rvalid, r_host_rvalid;
  logic [DW-1:0] r_cpu_rdat, r_host_rdat;
  mem_req_t      w_mem_rq;

  assign w_cpu_starved  = (w_cpu_wait  == WW'(MAXWAIT));
  assign w_host_starved = (w_host_wait == WW'(MAXWAIT));

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_last  <= OWN_HOST;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // grant decision and next state
  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_host_gnt  = 1'b0;
    w_state_nxt = S_IDLE;
    w_last_nxt  = r_last;
    if (cpu_req && !host_req) begin
      w_cpu_gnt = 1'b1;
    end else if (host_req && !cpu_req) begin
      w_host_gnt = 1'b1;
    end else if (cpu_req && host_req) begin
      // In a locked burst the host keeps the port even if host_lock has just
      // dropped; only a saturated lock counter hands one cycle to the CPU.
      if (r_state == S_HLOCK) begin
        if (w_lock_cnt == LW'(MAXLOCK)) w_cpu_gnt  = 1'b1;
        else                            w_host_gnt = 1'b1;
      end else if (w_cpu_starved && !w_host_starved) begin
        w_cpu_gnt = 1'b1;
      end else if (w_host_starved && !w_cpu_starved) begin
        w_host_gnt = 1'b1;
      end else if (r_last == OWN_HOST) begin
        w_cpu_gnt = 1'b1;
      end else begin
        w_host_gnt = 1'b1;
      end
    end
    // reset kills grants combinationally so an in-flight write aborts at once
    if (!reset) begin
      w_cpu_gnt  = 1'b0;
      w_host_gnt = 1'b0;
    end
    if (w_cpu_gnt) begin
      w_state_nxt = S_CPU;
      w_last_nxt  = OWN_CPU;
    end else if (w_host_gnt) begin
      w_state_nxt = host_lock ? S_HLOCK : S_HOST;
      w_last_nxt  = OWN_HOST;
    end
  end

  assign cpu_gnt   = w_cpu_gnt;
  assign host_gnt  = w_host_gnt;
  assign cpu_stall = cpu_req & ~w_cpu_gnt & reset;

  sat_ctr #(.W(WW), .MAX(MAXWAIT)) u_cpu_wait (
    .clk   (clk),
    .rst_n (reset),
    .i_inc (cpu_req & ~w_cpu_gnt),
    .i_clr (w_cpu_gnt | ~cpu_req),
    .o_cnt (w_cpu_wait)
  );

  sat_ctr #(.W(WW), .MAX(MAXWAIT)) u_host_wait (
    .clk   (clk),
    .rst_n (reset),
    .i_inc (host_req & ~w_host_gnt),
    .i_clr (w_host_gnt | ~host_req),
    .o_cnt (w_host_wait)
  );

  // Counts locked host grants that hold off a waiting CPU, including the one
  // that enters the burst, so MAXLOCK host grants precede the CPU's slot.
  sat_ctr #(.W(LW), .MAX(MAXLOCK)) u_lock (
    .clk   (clk),
    .rst_n (reset),
    .i_inc (w_host_gnt & host_lock & cpu_req),
    .i_clr (w_state_nxt != S_HLOCK),
    .o_cnt (w_lock_cnt)
  );

  // memory mux: idle bus is all zeros
  always_comb begin
    w_mem_rq = '0;
    if (w_cpu_gnt) begin
      w_mem_rq.we   = cpu_we;
      w_mem_rq.addr = cpu_addr;
      w_mem_rq.wdat = cpu_wdat;
    end else if (w_host_gnt) begin
      w_mem_rq.we   = host_we;
      w_mem_rq.addr = host_addr;
      w_mem_rq.wdat = host_wdat;
    end
  end

  assign mem_wr_en = w_mem_rq.we;
  assign mem_addr  = w_mem_rq.addr;
  assign mem_wdat  = w_mem_rq.wdat;

  // read-data return registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cpu_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_cpu_rdat    <= '0;
      r_host_rdat   <= '0;
    end else begin
      r_cpu_rvalid  <= w_cpu_gnt & ~cpu_we;
      r_host_rvalid <= w_host_gnt & ~host_we;
      if (w_cpu_gnt && !cpu_we)   r_cpu_rdat  <= mem_rdat;
      if (w_host_gnt && !host_we) r_host_rdat <= mem_rdat;
    end
  end

  assign cpu_rvalid  = r_cpu_rvalid;
  assign cpu_rdat    = r_cpu_rdat;
  assign host_rvalid = r_host_rvalid;
  assign host_rdat   = r_host_rdat;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed-vector bench for dmem_arbiter with a small
// behavioural dat_mem attached to the memory port.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic       clk, reset;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [7:0] cpu_addr, cpu_wdat, cpu_rdat;
  logic       host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [7:0] host_addr, host_wdat, host_rdat;
  logic       mem_wr_en;
  logic [7:0] mem_addr, mem_wdat, mem_rdat;

  logic [7:0] mem [0:255];
  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter #(.AW(8), .DW(8), .MAXWAIT(4), .MAXLOCK(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdat(cpu_wdat),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdat(cpu_rdat),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdat(host_wdat),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdat(host_rdat),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wdat;
  assign mem_rdat = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdat = 8'hA5;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdat = 8'h00; host_lock = 1'b0;

    // 1: reset blocks grant, release grants same cycle
    #3;
    chk("rst_cpu_gnt",   32'(cpu_gnt),    0);
    chk("rst_wr_en",     32'(mem_wr_en),  0);
    chk("rst_stall",     32'(cpu_stall),  0);
    chk("rst_rvalid",    32'(cpu_rvalid), 0);
    chk("rst_cpu_rdat",  32'(cpu_rdat),   0);
    chk("rst_host_rdat", 32'(host_rdat),  0);
    chk("rst_state",     32'(dut.r_state), 32'(S_IDLE));
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rel_cpu_gnt", 32'(cpu_gnt),   1);
    chk("rel_wr_en",   32'(mem_wr_en), 1);
    chk("rel_addr",    32'(mem_addr),  32'h10);
    chk("rel_wdat",    32'(mem_wdat),  32'hA5);
    chk("rel_stall",   32'(cpu_stall), 0);

    // 2: read back the stored byte
    @(posedge clk); #1;
    cpu_we = 1'b0;
    #1;
    chk("rd_gnt",        32'(cpu_gnt),    1);
    chk("rd_wr_en",      32'(mem_wr_en),  0);
    chk("wr_no_rvalid",  32'(cpu_rvalid), 0);
    @(posedge clk); #1;
    chk("rd_rvalid",     32'(cpu_rvalid), 1);
    chk("rd_rdat",       32'(cpu_rdat),   32'hA5);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("rd_rvalid_end", 32'(cpu_rvalid), 0);
    chk("rd_rdat_hold",  32'(cpu_rdat),   32'hA5);
    chk("idle_gnt",      32'(cpu_gnt),    0);
    chk("idle_addr",     32'(mem_addr),   0);
    chk("idle_stall",    32'(cpu_stall),  0);

    // 3: both requesting, no lock -> strict alternation, CPU first after reset
    reset = 1'b0; #1; reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("alt_cpu_gnt%0d", i),   32'(cpu_gnt),     32'(i % 2 == 0));
      chk($sformatf("alt_host_gnt%0d", i),  32'(host_gnt),    32'(i % 2 == 1));
      chk($sformatf("alt_stall%0d", i),     32'(cpu_stall),   32'(i % 2 == 1));
      chk($sformatf("alt_cpu_rv%0d", i),    32'(cpu_rvalid),  32'(i > 0 && (i - 1) % 2 == 0));
      chk($sformatf("alt_host_rv%0d", i),   32'(host_rvalid), 32'(i > 0 && (i - 1) % 2 == 1));
      @(posedge clk); #1;
    end
    chk("alt_host_rv_last", 32'(host_rvalid), 1);
    chk("alt_host_rdat",    32'(host_rdat),   32'hA5);

    // 4+5: locked host burst holds CPU off for 8 grants, CPU gets one slot,
    // host resumes; lock then drops and CPU gets the following cycle
    host_lock = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c == 12) host_lock = 1'b0;
      #1;
      chk($sformatf("lk_cpu_gnt%0d", c),  32'(cpu_gnt),   32'(c == 0 || c == 9 || c == 13));
      chk($sformatf("lk_host_gnt%0d", c), 32'(host_gnt),  32'(!(c == 0 || c == 9 || c == 13)));
      chk($sformatf("lk_stall%0d", c),    32'(cpu_stall), 32'(!(c == 0 || c == 9 || c == 13)));
      @(posedge clk); #1;
    end

    // 6: reset during a granted write
    host_req = 1'b0; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdat = 8'h77;
    #1;
    chk("w6_rvalid_pend", 32'(cpu_rvalid), 1);
    chk("w6_wr_en",       32'(mem_wr_en),  1);
    chk("w6_addr",        32'(mem_addr),   32'h20);
    reset = 1'b0;
    #1;
    chk("w6_wr_abort",  32'(mem_wr_en),  0);
    chk("w6_gnt_abort", 32'(cpu_gnt),    0);
    chk("w6_rv_lost",   32'(cpu_rvalid), 0);
    chk("w6_stall",     32'(cpu_stall),  0);
    @(posedge clk); #1;
    reset = 1'b1; host_req = 1'b1;
    #1;
    chk("w6_state_idle", 32'(dut.r_state), 32'(S_IDLE));
    chk("w6_cpu_first",  32'(cpu_gnt),     1);
    chk("w6_host_wait",  32'(host_gnt),    0);
    @(posedge clk); #1;
    chk("w6_mem_written", 32'(mem[8'h20]), 32'h77);
    chk("w6_host_next",   32'(host_gnt),   1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
